ysyx_22040759_scoreboard: RTL and testbench
===========================================

YSYX_22040759_SCOREBOARD -- requirements
Module: ysyx_22040759_scoreboard

Interface
REQ-001 SHALL define parameter NREG, default 32, meaning number of architectural integer registers (x0..x31).
REQ-002 SHALL define parameter CNTW, default 2, meaning width of each per-register pending-write counter (max count 3).
REQ-003 SHALL have port clock  input  1  rising-edge clock; one clock for the whole block.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports id_valid/id_rs1_ren/id_rs2_ren  input  1 each  ID instruction valid; rs1/rs2 read enables.
REQ-006 SHALL have ports id_rs1/id_rs2/id_rd  input  5 each  ID source and destination register indices.
REQ-007 SHALL have ports id_wen/id_isload  input  1 each  ID instruction writes rd; ID instruction is a load.
REQ-008 SHALL have port id_fire  input  1  ID->EX handoff accepted this cycle.
REQ-009 SHALL have ports ex_fire/ex_kill  input  1 each  EX->MEM handoff this cycle; EX instruction flushed this cycle.
REQ-010 SHALL have ports wb_valid/wb_wen  input  1 each, and wb_rd  input  5  register-file write retiring this cycle.
REQ-011 SHALL have port stall  output  1  hold ID (no id_fire allowed).
REQ-012 SHALL have ports rs1_busy/rs2_busy  output  1 each  ID source has >=1 pending write (forward path selection hint).
REQ-013 SHALL have port inflight  output  3  total pending writes across all registers, saturating at 7.
REQ-014 SHALL have port sb_err  output  1  sticky counter underflow/overflow error.

Function
REQ-015 SHALL keep cnt[r] per register r=1..NREG-1; cnt[0] SHALL read as 0 always and never change.
REQ-016 SHALL keep EX tracking registers ex_valid, ex_rd, ex_wen, ex_isload.
REQ-017 Issue: on id_fire with id_wen=1, id_rd!=0, cnt[id_rd] SHALL increment by 1 at the next edge.
REQ-018 Retire: on wb_valid&wb_wen with wb_rd!=0, cnt[wb_rd] SHALL decrement by 1 at the next edge.
REQ-019 Kill: on ex_kill with ex_valid=1, ex_wen=1, ex_rd!=0, cnt[ex_rd] SHALL decrement by 1 and ex_valid SHALL clear.
REQ-020 Simultaneous events on one register SHALL sum: next = cnt + issue - retire - kill, all in the same cycle.
REQ-021 A net result below 0 SHALL clamp to 0 and set sb_err; above 3 SHALL clamp to 3 and set sb_err; sb_err clears only on reset.
REQ-022 EX tracking: id_fire SHALL load ex_* from id_* (ex_valid=1); else ex_kill or ex_fire SHALL clear ex_valid; else hold.
REQ-023 id_fire with ex_kill in one cycle: kill SHALL apply to the old EX entry and the new instruction SHALL load EX.
REQ-024 Load-use hazard (combinational) = id_valid & ex_valid & ex_isload & ex_wen & ex_rd!=0 & ((id_rs1_ren & id_rs1==ex_rd) | (id_rs2_ren & id_rs2==ex_rd)).
REQ-025 WAW overflow hazard (combinational) = id_valid & id_wen & id_rd!=0 & cnt[id_rd]==3.
REQ-026 stall SHALL equal load-use hazard OR WAW overflow hazard, with zero-cycle latency from inputs.
REQ-027 id_fire while stall=1 SHALL be ignored (no count or EX update) and SHALL set sb_err.
REQ-028 rs1_busy SHALL equal id_rs1_ren & id_rs1!=0 & cnt[id_rs1]!=0; rs2_busy likewise; both combinational, pre-update values.
REQ-029 inflight SHALL be registered sum of all cnt[r], saturated to 7, updated in the same edge as the counters.

Reset
REQ-030 Under reset all cnt[r]=0, ex_valid=0, ex_rd=0, ex_wen=0, ex_isload=0, sb_err=0, inflight=0 at the next edge.
REQ-031 Reset SHALL override every concurrent issue/retire/kill event, including mid-operation; stall/busy then follow reset state (0 unless load-use cannot occur, i.e. 0).

Verification
REQ-032 Issue add x5 (id_fire, id_rd=5), next cycle ID reads rs1=5 -> rs1_busy=1, stall=0; wb_rd=5 retires -> cnt[5]=0, rs1_busy=0.
REQ-033 Issue ld x7, next cycle ID add rs2=7 -> stall=1 while ex_valid; ex_fire -> stall=0 next cycle.
REQ-034 Three issues to x3 without retire -> cnt[3]=3, inflight=3; fourth ID with rd=3 -> stall=1; one retire -> stall=0.
REQ-035 Same-cycle id_fire rd=9 and retire wb_rd=9 with cnt[9]=1 -> cnt[9] stays 1; ex_kill of that EX rd=9 -> cnt[9]=0.
REQ-036 Retire wb_rd=4 with cnt[4]=0 -> cnt[4]=0, sb_err=1 sticky; rd=0 issue/retire -> no change, no error.
REQ-037 Reset asserted with cnt[6]=2 and ex_valid=1 plus concurrent id_fire -> all counters 0, ex_valid=0, inflight=0.

Source files
------------

// File: rtl/ysyx_22040759_scoreboard.sv
// Register scoreboard: per-register pending-write counters, EX-stage tracking,
// load-use / WAW-overflow stall generation and a sticky consistency error flag.
module ysyx_22040759_scoreboard #(
   parameter int NREG = 32,
   parameter int CNTW = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       id_valid,
   input  logic       id_rs1_ren,
   input  logic       id_rs2_ren,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] id_rd,
   input  logic       id_wen,
   input  logic       id_isload,
   input  logic       id_fire,
   input  logic       ex_fire,
   input  logic       ex_kill,
   input  logic       wb_valid,
   input  logic       wb_wen,
   input  logic [4:0] wb_rd,
   output logic       stall,
   output logic       rs1_busy,
   output logic       rs2_busy,
   output logic [2:0] inflight,
   output logic       sb_err
);

   localparam int              SW   = CNTW + 2;
   localparam logic [CNTW-1:0] CMAX = '1;

   // x0 has no storage: it always reads as zero pending writes
   logic [NREG-1:1][CNTW-1:0] cnt_q, cnt_d;
   logic                      ex_valid_q, ex_valid_d;
   logic [4:0]                ex_rd_q, ex_rd_d;
   logic                      ex_wen_q, ex_wen_d;
   logic                      ex_isload_q, ex_isload_d;
   logic [2:0]                inflight_q, inflight_d;
   logic                      sb_err_q, sb_err_d;

   logic [CNTW-1:0] rd_cnt, rs1_cnt, rs2_cnt;
   logic            load_use, waw, issue_ok, bad_fire, kill_ok, clamp_err;

   // look up the current counts of the ID operands (index 0 or out of range reads 0)
   always_comb begin
      rd_cnt  = '0;
      rs1_cnt = '0;
      rs2_cnt = '0;
      for (int r = 1; r < NREG; r++) begin
         if (id_rd  == 5'(r)) rd_cnt  = cnt_q[r];
         if (id_rs1 == 5'(r)) rs1_cnt = cnt_q[r];
         if (id_rs2 == 5'(r)) rs2_cnt = cnt_q[r];
      end
   end

   // hazard detection and stall, purely from current inputs and state
   always_comb begin
      load_use = id_valid & ex_valid_q & ex_isload_q & ex_wen_q & (ex_rd_q != 5'd0) &
                 ((id_rs1_ren & (id_rs1 == ex_rd_q)) | (id_rs2_ren & (id_rs2 == ex_rd_q)));
      waw      = id_valid & id_wen & (id_rd != 5'd0) & (rd_cnt == CMAX);
      stall    = load_use | waw;
      rs1_busy = id_rs1_ren & (id_rs1 != 5'd0) & (rs1_cnt != '0);
      rs2_busy = id_rs2_ren & (id_rs2 != 5'd0) & (rs2_cnt != '0);
      // a handoff attempted under stall is dropped and flagged
      issue_ok = id_fire & ~stall;
      bad_fire = id_fire & stall;
      kill_ok  = ex_kill & ex_valid_q & ex_wen_q & (ex_rd_q != 5'd0);
   end

   // counter update: issue, retire and kill on the same register all sum, then clamp
   always_comb begin
      logic [SW-1:0] up, dn;
      logic [15:0]   tot;
      cnt_d     = cnt_q;
      clamp_err = 1'b0;
      tot       = '0;
      for (int r = 1; r < NREG; r++) begin
         up = SW'(cnt_q[r]) + SW'(issue_ok & id_wen & (id_rd == 5'(r)));
         dn = SW'(wb_valid & wb_wen & (wb_rd == 5'(r))) + SW'(kill_ok & (ex_rd_q == 5'(r)));
         if (up < dn) begin
            cnt_d[r]  = '0;
            clamp_err = 1'b1;
         end else if ((up - dn) > SW'(CMAX)) begin
            cnt_d[r]  = CMAX;
            clamp_err = 1'b1;
         end else begin
            cnt_d[r]  = CNTW'(up - dn);
         end
         tot = tot + 16'(cnt_d[r]);
      end
      inflight_d = (tot > 16'd7) ? 3'd7 : tot[2:0];
      sb_err_d   = sb_err_q | clamp_err | bad_fire;
   end

   // EX tracking: a new issue overwrites (after any kill of the old entry took effect)
   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_rd_d     = ex_rd_q;
      ex_wen_d    = ex_wen_q;
      ex_isload_d = ex_isload_q;
      if (issue_ok) begin
         ex_valid_d  = 1'b1;
         ex_rd_d     = id_rd;
         ex_wen_d    = id_wen;
         ex_isload_d = id_isload;
      end else if (ex_kill | ex_fire) begin
         ex_valid_d  = 1'b0;
      end
   end

   // state registers with synchronous reset overriding every concurrent event
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q       <= '0;
         ex_valid_q  <= 1'b0;
         ex_rd_q     <= 5'd0;
         ex_wen_q    <= 1'b0;
         ex_isload_q <= 1'b0;
         inflight_q  <= 3'd0;
         sb_err_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         ex_valid_q  <= ex_valid_d;
         ex_rd_q     <= ex_rd_d;
         ex_wen_q    <= ex_wen_d;
         ex_isload_q <= ex_isload_d;
         inflight_q  <= inflight_d;
         sb_err_q    <= sb_err_d;
      end
   end

   assign inflight = inflight_q;
   assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_ysyx_22040759_scoreboard.sv
// Self-checking bench for the register scoreboard: directed scenarios plus
// randomized traffic checked against a per-register count model.
module tb_ysyx_22040759_scoreboard;

   logic       clock = 1'b0;
   logic       reset;
   logic       id_valid, id_rs1_ren, id_rs2_ren, id_wen, id_isload, id_fire;
   logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic       ex_fire, ex_kill, wb_valid, wb_wen;
   logic       stall, rs1_busy, rs2_busy, sb_err;
   logic [2:0] inflight;

   int checks = 0;
   int errors = 0;

   ysyx_22040759_scoreboard dut (
      .clock(clock), .reset(reset),
      .id_valid(id_valid), .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_wen(id_wen), .id_isload(id_isload), .id_fire(id_fire),
      .ex_fire(ex_fire), .ex_kill(ex_kill),
      .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
      .stall(stall), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .inflight(inflight), .sb_err(sb_err)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   int m_cnt[32];
   bit m_exv, m_exw, m_exl, m_err;
   int m_exrd;

   function automatic bit m_stall();
      bit lu, ww;
      lu = id_valid && m_exv && m_exl && m_exw && (m_exrd != 0) &&
           ((id_rs1_ren && (int'(id_rs1) == m_exrd)) || (id_rs2_ren && (int'(id_rs2) == m_exrd)));
      ww = id_valid && id_wen && (id_rd != 0) && (m_cnt[id_rd] == 3);
      return lu || ww;
   endfunction

   function automatic bit m_busy(input bit ren, input logic [4:0] rs);
      return ren && (rs != 0) && (m_cnt[rs] != 0);
   endfunction

   function automatic int m_infl();
      int s = 0;
      for (int r = 0; r < 32; r++) s += m_cnt[r];
      return (s > 7) ? 7 : s;
   endfunction

   task automatic m_tick();
      int  d[32];
      bit  st, ok, kill;
      if (reset) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
         m_exv = 0; m_exw = 0; m_exl = 0; m_exrd = 0; m_err = 0;
         return;
      end
      for (int r = 0; r < 32; r++) d[r] = 0;
      st   = m_stall();
      ok   = id_fire && !st;
      kill = ex_kill && m_exv && m_exw && (m_exrd != 0);
      if (id_fire && st) m_err = 1;
      if (ok && id_wen && id_rd != 0) d[id_rd] += 1;
      if (wb_valid && wb_wen && wb_rd != 0) d[wb_rd] -= 1;
      if (kill) d[m_exrd] -= 1;
      for (int r = 1; r < 32; r++) begin
         int n = m_cnt[r] + d[r];
         if (n < 0) begin n = 0; m_err = 1; end
         if (n > 3) begin n = 3; m_err = 1; end
         m_cnt[r] = n;
      end
      if (ok) begin
         m_exv = 1; m_exrd = id_rd; m_exw = id_wen; m_exl = id_isload;
      end else if (ex_kill || ex_fire) m_exv = 0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      id_valid = 0; id_rs1_ren = 0; id_rs2_ren = 0; id_wen = 0; id_isload = 0; id_fire = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_fire = 0; ex_kill = 0;
      wb_valid = 0; wb_wen = 0; wb_rd = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      m_tick();
      #1;
   endtask

   task automatic do_reset();
      idle(); reset = 1; tick(); reset = 0;
   endtask

   task automatic issue(input logic [4:0] rd, input bit ld);
      idle(); id_valid = 1; id_fire = 1; id_wen = 1; id_rd = rd; id_isload = ld; tick(); idle();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle(); reset = 1; id_fire = 1; id_wen = 1; id_rd = 5; tick(); tick(); reset = 0; idle();
      id_valid = 1; id_rs1_ren = 1; id_rs1 = 5; #1;
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rst_inflight got %0d exp 0", inflight); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", sb_err); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall); end
      checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", rs1_busy); end
   endtask

   task automatic test_issue_retire();
      do_reset(); issue(5, 0);
      checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL ir_inflight got %0d exp 1", inflight); end
      id_valid = 1; id_rs1_ren = 1; id_rs1 = 5; #1;
      checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL ir_busy got %b exp 1", rs1_busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ir_stall got %b exp 0", stall); end
      wb_valid = 1; wb_wen = 1; wb_rd = 5; tick(); wb_valid = 0; wb_wen = 0; #1;
      checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL ir_busy_after got %b exp 0", rs1_busy); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL ir_inflight_after got %0d exp 0", inflight); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL ir_err got %b exp 0", sb_err); end
   endtask

   task automatic test_load_use();
      do_reset(); issue(7, 1);
      id_valid = 1; id_rs2_ren = 1; id_rs2 = 7; id_wen = 1; id_rd = 8; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
      checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL lu_busy got %b exp 1", rs2_busy); end
      tick();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_hold got %b exp 1", stall); end
      ex_fire = 1; tick(); ex_fire = 0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall); end
   endtask

   task automatic test_stall_fire();
      do_reset(); issue(7, 1);
      id_valid = 1; id_rs1_ren = 1; id_rs1 = 7; id_wen = 1; id_rd = 9; id_fire = 1; tick(); id_fire = 0; #1;
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sf_err got %b exp 1", sb_err); end
      checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL sf_inflight got %0d exp 1", inflight); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sf_ex_kept got %b exp 1", stall); end
   endtask

   task automatic test_waw();
      do_reset(); issue(3, 0); issue(3, 0); issue(3, 0);
      checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL waw_inflight got %0d exp 3", inflight); end
      id_valid = 1; id_wen = 1; id_rd = 3; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", stall); end
      wb_valid = 1; wb_wen = 1; wb_rd = 3; tick(); wb_valid = 0; wb_wen = 0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_release got %b exp 0", stall); end
      checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL waw_inflight2 got %0d exp 2", inflight); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL waw_err got %b exp 0", sb_err); end
   endtask

   task automatic test_same_cycle();
      do_reset(); issue(9, 0);
      id_valid = 1; id_fire = 1; id_wen = 1; id_rd = 9; wb_valid = 1; wb_wen = 1; wb_rd = 9; tick(); idle();
      id_valid = 1; id_rs1_ren = 1; id_rs1 = 9; #1;
      checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL sc_inflight got %0d exp 1", inflight); end
      checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sc_busy got %b exp 1", rs1_busy); end
      ex_kill = 1; tick(); ex_kill = 0; #1;
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL sc_kill_inflight got %0d exp 0", inflight); end
      checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sc_kill_busy got %b exp 0", rs1_busy); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sc_err got %b exp 0", sb_err); end
   endtask

   task automatic test_underflow_x0();
      do_reset(); issue(0, 0);
      wb_valid = 1; wb_wen = 1; wb_rd = 0; tick(); idle();
      id_valid = 1; id_rs1_ren = 1; id_rs1 = 0; #1;
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL x0_err got %b exp 0", sb_err); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL x0_inflight got %0d exp 0", inflight); end
      checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got %b exp 0", rs1_busy); end
      wb_valid = 1; wb_wen = 1; wb_rd = 4; tick(); idle();
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL uf_err got %b exp 1", sb_err); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL uf_inflight got %0d exp 0", inflight); end
      tick(); tick();
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", sb_err); end
   endtask

   task automatic test_reset_mid();
      do_reset(); issue(6, 0); issue(6, 1);
      checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL rm_pre got %0d exp 2", inflight); end
      reset = 1; id_valid = 1; id_fire = 1; id_wen = 1; id_rd = 6; tick(); reset = 0; idle();
      id_valid = 1; id_rs1_ren = 1; id_rs1 = 6; #1;
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rm_inflight got %0d exp 0", inflight); end
      checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", rs1_busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_stall got %b exp 0", stall); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         idle();
         reset      = ($urandom_range(99) == 0);
         id_valid   = ($urandom_range(9) != 0);
         id_rs1_ren = $urandom_range(1); id_rs2_ren = $urandom_range(1);
         id_rs1 = 5'($urandom_range(7)); id_rs2 = 5'($urandom_range(7)); id_rd = 5'($urandom_range(7));
         id_wen = ($urandom_range(3) != 0); id_isload = $urandom_range(1);
         ex_fire = $urandom_range(1); ex_kill = ($urandom_range(9) == 0);
         wb_valid = $urandom_range(1); wb_wen = $urandom_range(1); wb_rd = 5'($urandom_range(7));
         id_fire = m_stall() ? ($urandom_range(49) == 0) : ($urandom_range(3) != 0);
         #1;
         checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", i, stall, m_stall()); end
         checks++; if (rs1_busy !== m_busy(id_rs1_ren, id_rs1)) begin errors++; $display("FAIL rnd_busy1 cyc %0d got %b exp %b", i, rs1_busy, m_busy(id_rs1_ren, id_rs1)); end
         checks++; if (rs2_busy !== m_busy(id_rs2_ren, id_rs2)) begin errors++; $display("FAIL rnd_busy2 cyc %0d got %b exp %b", i, rs2_busy, m_busy(id_rs2_ren, id_rs2)); end
         tick();
         checks++; if (int'(inflight) !== m_infl()) begin errors++; $display("FAIL rnd_inflight cyc %0d got %0d exp %0d", i, inflight, m_infl()); end
         checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", i, sb_err, m_err); end
      end
      reset = 0; idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      idle(); reset = 1;
      test_reset();
      test_issue_retire();
      test_load_use();
      test_stall_fire();
      test_waw();
      test_same_cycle();
      test_underflow_x0();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
